// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory handshakes around the shared memory port.
// The arbiter uses the slave modport. Requesters and memory sit on the master side.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_ready;
    logic [63:0] if_rdata;

    logic        dm_req;
    logic        dm_we;
    logic [63:0] dm_addr;
    logic [63:0] dm_wdata;
    logic        dm_ready;
    logic [63:0] dm_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    logic        sel;
    logic        err_timeout;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
        output if_ready, if_rdata, dm_ready, dm_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, sel, err_timeout
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
        input  if_ready, if_rdata, dm_ready, dm_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, sel, err_timeout
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one 64-bit memory port between instruction fetch and data access.
// Data has priority. A streak limit guarantees fetch progress, and a timeout aborts hung accesses.
module mem_port_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input logic              clk,
    input logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STREAK_MAX   = SW'(MAX_D_STREAK);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} state_t;

    state_t        state;
    logic [SW-1:0] streak;
    logic [TW-1:0] tcnt;
    logic          data_wins;

    // Data wins unless fetch has been waiting through a full streak of data grants.
    assign data_wins = bus.dm_req && !(bus.if_req && streak == STREAK_MAX);

    // NOTE: every register, including the memory-side request, clears asynchronously so an
    // access in flight is dropped the moment rst_n falls, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            streak          <= '0;
            tcnt            <= '0;
            bus.mem_req     <= 1'b0;
            bus.mem_we      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= '0;
            bus.if_ready    <= 1'b0;
            bus.dm_ready    <= 1'b0;
            bus.if_rdata    <= '0;
            bus.dm_rdata    <= '0;
            bus.sel         <= 1'b0;
            bus.err_timeout <= 1'b0;
        end else begin
            // NOTE: ready pulses default low here so they last exactly one cycle (the RESP cycle).
            bus.if_ready <= 1'b0;
            bus.dm_ready <= 1'b0;

            case (state)
                IDLE: begin
                    if (data_wins) begin
                        state         <= GNT_D;
                        bus.sel       <= 1'b1;
                        bus.mem_req   <= 1'b1;
                        bus.mem_addr  <= bus.dm_addr;
                        bus.mem_we    <= bus.dm_we;
                        bus.mem_wdata <= bus.dm_wdata;
                        tcnt          <= '0;
                        // data_wins with if_req pending implies streak < STREAK_MAX, so no overflow
                        streak        <= bus.if_req ? streak + 1'b1 : '0;
                    end else if (bus.if_req) begin
                        state         <= GNT_I;
                        bus.sel       <= 1'b0;
                        bus.mem_req   <= 1'b1;
                        bus.mem_addr  <= bus.if_addr;
                        bus.mem_we    <= 1'b0;
                        bus.mem_wdata <= '0;
                        tcnt          <= '0;
                        streak        <= '0;
                    end
                end

                GNT_I, GNT_D: begin
                    if (bus.mem_ack || tcnt == TIMEOUT_LAST) begin
                        state       <= RESP;
                        bus.mem_req <= 1'b0;
                        if (!bus.mem_ack) bus.err_timeout <= 1'b1;
                        if (state == GNT_I) begin
                            bus.if_ready <= 1'b1;
                            bus.if_rdata <= bus.mem_ack ? bus.mem_rdata : '0;
                        end else begin
                            bus.dm_ready <= 1'b1;
                            // a completed store leaves the load-data register untouched
                            if (!bus.mem_ack)     bus.dm_rdata <= '0;
                            else if (!bus.mem_we) bus.dm_rdata <= bus.mem_rdata;
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios, then randomized traffic
// scored against a transaction-level model of the arbitration and memory contents.
module tb_mem_port_arbiter;
    localparam int MAX_D = 4;
    localparam int TOUT  = 8;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_port_arbiter_if p ();

    mem_port_arbiter #(.MAX_D_STREAK(MAX_D), .TIMEOUT(TOUT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] mem_model [logic [63:0]];

    function automatic logic [63:0] rd(input logic [63:0] a);
        return mem_model.exists(a) ? mem_model[a] : ~a;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // randomized-phase model state
    bit          fq, dq, dwe, ack;
    bit          s_fq, s_dq, s_dwe, s_ack;
    logic [63:0] fa, da, dwd, s_fa, s_da, s_dwd;
    bit          m_busy, m_resp, g_we;
    int          owner, d_streak, wait_left, n;
    logic [63:0] g_addr, g_wd, ack_data, exp_if_rdata, exp_dm_rdata;

    initial begin
        rst_n = 1'b0;
        p.if_req = 0; p.if_addr = 0; p.dm_req = 0; p.dm_we = 0; p.dm_addr = 0; p.dm_wdata = 0;
        p.mem_ack = 0; p.mem_rdata = 0;
        step();
        step();
        check("rst_mem_req",   p.mem_req, 0);
        check("rst_mem_we",    p.mem_we, 0);
        check("rst_mem_addr",  p.mem_addr, 0);
        check("rst_mem_wdata", p.mem_wdata, 0);
        check("rst_if_ready",  p.if_ready, 0);
        check("rst_dm_ready",  p.dm_ready, 0);
        check("rst_if_rdata",  p.if_rdata, 0);
        check("rst_dm_rdata",  p.dm_rdata, 0);
        check("rst_sel",       p.sel, 0);
        check("rst_err",       p.err_timeout, 0);
        rst_n = 1'b1;

        // fetch only, ack in the second grant cycle
        p.if_req = 1; p.if_addr = 64'h1000;
        step();
        check("fetch_req",  p.mem_req, 1);
        check("fetch_sel",  p.sel, 0);
        check("fetch_addr", p.mem_addr, 64'h1000);
        check("fetch_we",   p.mem_we, 0);
        step();
        check("fetch_req_hold", p.mem_req, 1);
        p.mem_ack = 1; p.mem_rdata = 64'h13;
        step();
        p.mem_ack = 0; p.if_req = 0;
        check("fetch_ready",    p.if_ready, 1);
        check("fetch_rdata",    p.if_rdata, 64'h13);
        check("fetch_dm_ready", p.dm_ready, 0);
        check("fetch_req_drop", p.mem_req, 0);
        step();
        check("fetch_ready_pulse", p.if_ready, 0);

        // store held three cycles before ack
        p.dm_req = 1; p.dm_we = 1; p.dm_addr = 64'h2008; p.dm_wdata = 64'hDEADBEEF;
        step();
        for (int c = 0; c < 3; c++) begin
            check("store_req",   p.mem_req, 1);
            check("store_sel",   p.sel, 1);
            check("store_we",    p.mem_we, 1);
            check("store_addr",  p.mem_addr, 64'h2008);
            check("store_wdata", p.mem_wdata, 64'hDEADBEEF);
            if (c < 2) step();
        end
        p.mem_ack = 1; p.mem_rdata = 64'hBAD0BAD0;
        step();
        p.mem_ack = 0; p.dm_req = 0; p.dm_we = 0;
        check("store_ready",    p.dm_ready, 1);
        check("store_rdata",    p.dm_rdata, 0);
        check("store_if_ready", p.if_ready, 0);
        step();
        check("store_ready_pulse", p.dm_ready, 0);

        // simultaneous requests: data first, then fetch
        p.if_req = 1; p.if_addr = 64'h1100;
        p.dm_req = 1; p.dm_we = 0; p.dm_addr = 64'h2010;
        step();
        check("sim_sel_d",  p.sel, 1);
        check("sim_addr_d", p.mem_addr, 64'h2010);
        p.mem_ack = 1; p.mem_rdata = 64'h5555;
        step();
        p.mem_ack = 0; p.dm_req = 0;
        check("sim_dm_ready", p.dm_ready, 1);
        check("sim_dm_rdata", p.dm_rdata, 64'h5555);
        step();
        check("sim_idle_req", p.mem_req, 0);
        step();
        check("sim_sel_f",  p.sel, 0);
        check("sim_addr_f", p.mem_addr, 64'h1100);
        check("sim_req_f",  p.mem_req, 1);
        p.mem_ack = 1; p.mem_rdata = 64'h77;
        step();
        p.mem_ack = 0;
        check("sim_if_ready", p.if_ready, 1);
        check("sim_if_rdata", p.if_rdata, 64'h77);

        // starvation guard: both held continuously -> DDDDF DDDDF
        p.dm_req = 1; p.dm_we = 0; p.dm_addr = 64'h2020;
        for (int g = 0; g < 10; g++) begin
            n = 0;
            while (p.mem_req !== 1'b1 && n < 10) begin
                step();
                n++;
            end
            check("starve_req", p.mem_req, 1);
            check("starve_sel", p.sel, (g % 5 == 4) ? 64'd0 : 64'd1);
            p.mem_ack = 1; p.mem_rdata = 64'(g);
            step();
            p.mem_ack = 0;
        end
        p.if_req = 0; p.dm_req = 0;
        step();

        // timeout: no ack ever
        p.if_req = 1; p.if_addr = 64'h1200;
        step();
        n = 0;
        while (p.mem_req === 1'b1 && n < 20) begin
            n++;
            step();
        end
        check("to_cycles",   64'(n), 64'(TOUT));
        check("to_if_ready", p.if_ready, 1);
        check("to_if_rdata", p.if_rdata, 0);
        check("to_err",      p.err_timeout, 1);
        check("to_dm_ready", p.dm_ready, 0);
        p.if_req = 0;
        repeat (3) step();
        check("to_err_sticky", p.err_timeout, 1);
        check("to_ready_low",  p.if_ready, 0);

        // asynchronous reset during the second cycle of a data grant
        p.dm_req = 1; p.dm_we = 1; p.dm_addr = 64'h2030; p.dm_wdata = 64'h1234;
        step();
        check("ar_req1", p.mem_req, 1);
        step();
        check("ar_req2", p.mem_req, 1);
        check("ar_sel2", p.sel, 1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_mem_req",  p.mem_req, 0);
        check("ar_sel",      p.sel, 0);
        check("ar_err",      p.err_timeout, 0);
        check("ar_dm_ready", p.dm_ready, 0);
        check("ar_if_ready", p.if_ready, 0);
        p.dm_req = 0; p.dm_we = 0;
        step();
        rst_n = 1'b1;
        p.if_req = 1; p.if_addr = 64'h3000;
        step();
        check("ar_f_req",  p.mem_req, 1);
        check("ar_f_sel",  p.sel, 0);
        check("ar_f_addr", p.mem_addr, 64'h3000);
        p.mem_ack = 1; p.mem_rdata = 64'hABCD;
        step();
        p.mem_ack = 0; p.if_req = 0;
        check("ar_f_ready",    p.if_ready, 1);
        check("ar_f_rdata",    p.if_rdata, 64'hABCD);
        check("ar_f_dm_ready", p.dm_ready, 0);
        step();

        // randomized traffic against the transaction model
        fq = 0; dq = 0; fa = 0; da = 0; dwe = 0; dwd = 0; ack = 0;
        m_busy = 0; m_resp = 0; owner = 0; d_streak = 0; wait_left = 0;
        g_addr = 0; g_wd = 0; g_we = 0; ack_data = 0;
        exp_if_rdata = 64'hABCD; exp_dm_rdata = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            s_fq = fq; s_dq = dq; s_fa = fa; s_da = da; s_dwe = dwe; s_dwd = dwd; s_ack = ack;
            step();
            if (m_busy) begin
                if (s_ack) begin
                    m_busy = 0;
                    m_resp = 1;
                    if (owner == 0)  exp_if_rdata = ack_data;
                    else if (!g_we)  exp_dm_rdata = ack_data;
                end
            end else if (m_resp) begin
                m_resp = 0;
            end else if (s_fq || s_dq) begin
                m_busy = 1;
                if (s_dq && !(s_fq && d_streak >= MAX_D)) begin
                    owner = 1; g_addr = s_da; g_we = s_dwe; g_wd = s_dwd;
                    d_streak = s_fq ? d_streak + 1 : 0;
                end else begin
                    owner = 0; g_addr = s_fa; g_we = 0; g_wd = 0;
                    d_streak = 0;
                end
                wait_left = $urandom_range(0, 3);
            end

            check("rnd_mem_req",  p.mem_req, 64'(m_busy));
            check("rnd_if_ready", p.if_ready, 64'(m_resp && owner == 0));
            check("rnd_dm_ready", p.dm_ready, 64'(m_resp && owner == 1));
            check("rnd_if_rdata", p.if_rdata, exp_if_rdata);
            check("rnd_dm_rdata", p.dm_rdata, exp_dm_rdata);
            check("rnd_err",      p.err_timeout, 0);
            if (m_busy) begin
                check("rnd_sel",   p.sel, 64'(owner));
                check("rnd_addr",  p.mem_addr, g_addr);
                check("rnd_we",    p.mem_we, 64'(g_we));
                check("rnd_wdata", p.mem_wdata, g_wd);
            end

            if (fq && m_resp && owner == 0) fq = 0;
            if (dq && m_resp && owner == 1) dq = 0;
            if (!fq && $urandom_range(0, 1) == 0) begin
                fq = 1;
                fa = 64'($urandom_range(0, 15)) << 3;
            end
            if (!dq && $urandom_range(0, 1) == 0) begin
                dq  = 1;
                da  = 64'($urandom_range(0, 15)) << 3;
                dwe = 1'($urandom_range(0, 1));
                dwd = {$urandom, $urandom};
            end

            ack = 0;
            p.mem_rdata = {$urandom, $urandom};
            if (m_busy) begin
                if (wait_left == 0) begin
                    ack = 1;
                    if (owner == 1 && g_we) begin
                        mem_model[g_addr] = g_wd;
                    end else begin
                        ack_data    = rd(g_addr);
                        p.mem_rdata = ack_data;
                    end
                end else begin
                    wait_left--;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                ack = 1;  // stray ack outside a grant must be ignored
            end
            p.mem_ack = ack;
            p.if_req = fq; p.if_addr = fa;
            p.dm_req = dq; p.dm_we = dwe; p.dm_addr = da; p.dm_wdata = dwd;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one 64-bit memory port between the instruction-fetch side (IF stage) and the data-access side (MEM stage) of the 5-stage pipeline.
- Runs a request/ready handshake with each side and a request/ack handshake with the memory.
- Drives the select of the 64-bit 2:1 address/data mux in front of the memory.
- Data side has priority; a streak counter guarantees fetch progress, and a timeout counter flags a hung memory.

Parameters:
- MAX_D_STREAK, 4, max consecutive data grants while if_req is pending before fetch is forced (must be >=1).
- TIMEOUT, 255, max cycles in a grant state waiting for mem_ack before abort (must be >=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held high until if_ready.
- if_addr  in  64  fetch address.
- if_ready  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  64  fetched instruction word, registered.
- dm_req  in  1  data request; held high until dm_ready.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  64  data address.
- dm_wdata  in  64  store data.
- dm_ready  out  1  one-cycle pulse: load data valid or store done.
- dm_rdata  out  64  load data, registered.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  64  memory address, registered.
- mem_wdata  out  64  memory write data, registered.
- mem_ack  in  1  memory completion; mem_rdata valid in this cycle.
- mem_rdata  in  64  memory read data.
- sel  out  1  mux select / current owner: 0 = fetch, 1 = data.
- err_timeout  out  1  sticky: a memory access timed out.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, if_ready, dm_ready, if_rdata, dm_rdata, sel, err_timeout. Streak and timeout counters 0.
- States: IDLE, GNT_I, GNT_D, RESP.
- IDLE, arbitration at the clock edge:
  - dm_req=1 and not (if_req=1 and streak==MAX_D_STREAK): go to GNT_D, sel<=1; latch dm_addr/dm_we/dm_wdata into mem_addr/mem_we/mem_wdata; streak<=streak+1 if if_req=1, else 0.
  - Otherwise if_req=1: go to GNT_I, sel<=0; mem_addr<=if_addr, mem_we<=0, mem_wdata<=0; streak<=0.
  - No request: stay in IDLE. sel keeps its last value.
- GNT_I / GNT_D:
  - mem_req=1 for the whole state. Address, write enable and write data stay stable.
  - Timeout counter increments each cycle.
  - On mem_ack=1: capture mem_rdata into the owner's rdata register (dm_rdata unchanged on stores), pulse the owner's ready in the next cycle, go to RESP, clear mem_req.
  - Timeout counter reaches TIMEOUT with no ack: go to RESP, owner rdata<=0, ready pulses, err_timeout<=1, mem_req cleared.
- RESP: exactly one cycle. Exactly one ready is high. No arbitration; go to IDLE. A requester still asserting req in this cycle is treated as a new request in IDLE.
- Latency: req sampled at edge 0 -> mem_req high in cycle 1 -> ack in cycle k (k>=1) -> ready in cycle k+1. Minimum 2 cycles from request to ready; back-to-back throughput is one access per 3 cycles.
- mem_ack outside GNT states is ignored.
- if_ready and dm_ready are never high in the same cycle.
- Requester inputs change only while that side's req is low or ready is high; values latched at grant govern the access.
- Counter widths: streak is $clog2(MAX_D_STREAK+1) bits and saturates at MAX_D_STREAK; timeout is $clog2(TIMEOUT+1) bits and is cleared on entry to each GNT state.
- err_timeout clears only on reset.
- Reset mid-access: the transaction is dropped and mem_req falls asynchronously. The memory model must tolerate the abort. No ready pulse is issued.

Test Plan:
- Fetch only: if_req=1, if_addr=0x1000, mem_ack one cycle after mem_req with mem_rdata=0x00000013 -> sel=0, mem_addr=0x1000, mem_we=0, if_ready pulses 1 cycle with if_rdata=0x13, dm_ready stays 0.
- Store: dm_req=1, dm_we=1, dm_addr=0x2008, dm_wdata=0xDEADBEEF, ack after 3 cycles -> sel=1, mem_we=1, mem_wdata=0xDEADBEEF held 3 cycles, dm_ready pulse, dm_rdata unchanged.
- Simultaneous requests at the same edge -> data granted first, fetch granted at the next IDLE.
- Starvation guard, MAX_D_STREAK=4: dm_req and if_req held continuously -> 4 data grants, then 1 fetch grant, then the pattern repeats.
- Timeout, TIMEOUT=8: fetch with mem_ack never asserted -> mem_req high exactly 8 cycles, then if_ready pulses with if_rdata=0, err_timeout=1 and stays 1.
- Reset: rst_n low in the 2nd cycle of a data grant -> mem_req, sel, ready and err_timeout go to 0 immediately without waiting for clk; after release, a new fetch completes normally.
